// File: rtl/fifo_rd_stream.sv
// Read-side adapter for the async FIFO: turns rd_en/empty plus latency-delayed
// read data into a valid/ready stream, with a credit-limited skid buffer.
module fifo_rd_stream #(
  parameter int Width = 8,
  parameter int ReadLatency = 1,
  localparam int BufDepth = ReadLatency + 2,
  localparam int LevelW = $clog2(BufDepth + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  output logic              o_fifo_rd_en,
  input  logic              i_fifo_empty,
  input  logic [Width-1:0]  i_fifo_rd_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [Width-1:0]  o_data,
  output logic [LevelW-1:0] o_level
);

  // Stream handshake: a word transfers on any clk edge where o_valid && i_ready;
  // o_valid/o_data hold while o_valid && !i_ready.

  localparam int IdxW = $clog2(BufDepth);
  localparam logic [LevelW:0] DepthL = (LevelW + 1)'(BufDepth);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(BufDepth - 1);

  logic [Width-1:0]       mem [BufDepth];
  logic [IdxW-1:0]        wr_idx;
  logic [IdxW-1:0]        rd_idx;
  logic [LevelW-1:0]      count;
  logic [ReadLatency-1:0] tags;
  logic [LevelW:0]        inflight;
  logic [LevelW:0]        credit_used;
  logic                   push;
  logic                   pop;

  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] idx);
    return (idx == LastIdx) ? '0 : idx + 1'b1;
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < ReadLatency; i++) begin
      inflight = inflight + {{LevelW{1'b0}}, tags[i]};
    end
  end

  // Every outstanding read owns a buffer slot, so a return can never overflow.
  assign credit_used  = {1'b0, count} + inflight;
  assign o_fifo_rd_en = !rst && !i_flush && !i_fifo_empty && (credit_used < DepthL);

  assign push    = tags[ReadLatency-1];
  assign o_valid = (count != '0);
  assign pop     = o_valid && i_ready;
  assign o_data  = mem[rd_idx];
  assign o_level = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      wr_idx <= '0;
      rd_idx <= '0;
      tags   <= '0;
      for (int i = 0; i < BufDepth; i++) begin
        mem[i] <= '0;
      end
    end else if (i_flush) begin
      count  <= '0;
      wr_idx <= '0;
      rd_idx <= '0;
      tags   <= '0;
    end else begin
      tags[0] <= o_fifo_rd_en;
      for (int i = 1; i < ReadLatency; i++) begin
        tags[i] <= tags[i-1];
      end
      if (push) begin
        mem[wr_idx] <= i_fifo_rd_data;
        wr_idx      <= next_idx(wr_idx);
      end
      if (pop) begin
        rd_idx <= next_idx(rd_idx);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: two instances (ReadLatency 1 and 3), each fed by a
// queue-based FIFO model and checked against an owed-words scoreboard.
module tb_fifo_rd_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush_a, flush_b;
  logic       rd_en_a, rd_en_b;
  logic       empty_a = 1'b1, empty_b = 1'b1;
  logic [7:0] rd_data_a, rd_data_b;
  logic       valid_a, valid_b;
  logic       ready_a, ready_b;
  logic [7:0] data_a, data_b;
  logic [1:0] level_a;
  logic [2:0] level_b;

  int checks = 0;
  int errors = 0;
  int delivered_a = 0;
  int delivered_b = 0;

  logic [7:0] src_a[$];
  logic [7:0] src_b[$];
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  logic [7:0] dp_a;
  logic [7:0] dp_b [3];
  logic [7:0] word_a, word_b;
  logic       hold_a = 1'b0, hold_b = 1'b0;
  logic [7:0] hold_data_a, hold_data_b;

  always #5 clk = ~clk;

  fifo_rd_stream #(.Width(8), .ReadLatency(1)) dut_a (
    .clk(clk), .rst(rst), .i_flush(flush_a), .o_fifo_rd_en(rd_en_a),
    .i_fifo_empty(empty_a), .i_fifo_rd_data(rd_data_a), .o_valid(valid_a),
    .i_ready(ready_a), .o_data(data_a), .o_level(level_a)
  );

  fifo_rd_stream #(.Width(8), .ReadLatency(3)) dut_b (
    .clk(clk), .rst(rst), .i_flush(flush_b), .o_fifo_rd_en(rd_en_b),
    .i_fifo_empty(empty_b), .i_fifo_rd_data(rd_data_b), .o_valid(valid_b),
    .i_ready(ready_b), .o_data(data_b), .o_level(level_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // FIFO models: a read pops the queue head; the word shows up on rd_data
  // ReadLatency cycles later, with random garbage on every other cycle.
  always @(posedge clk) begin
    word_a = 8'($urandom_range(0, 255));
    if (rd_en_a && src_a.size() > 0) word_a = src_a.pop_front();
    dp_a    <= word_a;
    empty_a <= (src_a.size() == 0);
  end
  assign rd_data_a = dp_a;

  always @(posedge clk) begin
    word_b = 8'($urandom_range(0, 255));
    if (rd_en_b && src_b.size() > 0) word_b = src_b.pop_front();
    dp_b[0] <= word_b;
    dp_b[1] <= dp_b[0];
    dp_b[2] <= dp_b[1];
    empty_b <= (src_b.size() == 0);
  end
  assign rd_data_b = dp_b[2];

  // Scoreboards: exp_* holds every word read from the FIFO and not yet delivered.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_rd_en_a", 32'(rd_en_a), 32'd0);
      exp_a.delete();
      hold_a = 1'b0;
    end else begin
      check("no_overflow_a", 32'(exp_a.size() <= 3), 32'd1);
      check("level_le_owed_a", 32'(int'(level_a) <= exp_a.size()), 32'd1);
      if (hold_a) begin
        check("hold_valid_a", 32'(valid_a), 32'd1);
        check("hold_data_a", 32'(data_a), 32'(hold_data_a));
      end
      if (valid_a && ready_a) begin
        if (exp_a.size() == 0) check("unexpected_word_a", 32'(data_a), 32'hffff_ffff);
        else check("data_a", 32'(data_a), 32'(exp_a.pop_front()));
        delivered_a++;
      end
      if (flush_a) begin
        check("flush_rd_en_a", 32'(rd_en_a), 32'd0);
        exp_a.delete();
        hold_a = 1'b0;
      end else begin
        if (rd_en_a) begin
          if (src_a.size() == 0) check("read_while_empty_a", 32'(rd_en_a), 32'd0);
          else exp_a.push_back(src_a[0]);
        end
        hold_a = valid_a && !ready_a;
        hold_data_a = data_a;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("rst_rd_en_b", 32'(rd_en_b), 32'd0);
      exp_b.delete();
      hold_b = 1'b0;
    end else begin
      check("no_overflow_b", 32'(exp_b.size() <= 5), 32'd1);
      check("level_le_owed_b", 32'(int'(level_b) <= exp_b.size()), 32'd1);
      if (hold_b) begin
        check("hold_valid_b", 32'(valid_b), 32'd1);
        check("hold_data_b", 32'(data_b), 32'(hold_data_b));
      end
      if (valid_b && ready_b) begin
        if (exp_b.size() == 0) check("unexpected_word_b", 32'(data_b), 32'hffff_ffff);
        else check("data_b", 32'(data_b), 32'(exp_b.pop_front()));
        delivered_b++;
      end
      if (flush_b) begin
        check("flush_rd_en_b", 32'(rd_en_b), 32'd0);
        exp_b.delete();
        hold_b = 1'b0;
      end else begin
        if (rd_en_b) begin
          if (src_b.size() == 0) check("read_while_empty_b", 32'(rd_en_b), 32'd0);
          else exp_b.push_back(src_b[0]);
        end
        hold_b = valid_b && !ready_b;
        hold_data_b = data_b;
      end
    end
  end

  initial begin
    int first_rd, first_v, run, max_run, reads, base_a, base_b;
    logic stable, got;
    rst = 1'b1; flush_a = 1'b0; flush_b = 1'b0; ready_a = 1'b1; ready_b = 1'b1;

    // Reset then idle
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset_valid", 32'(valid_a), 32'd0);
      check("reset_rd_en", 32'(rd_en_a), 32'd0);
      check("reset_level", 32'(level_a), 32'd0);
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("idle_valid", 32'(valid_a), 32'd0);
      check("idle_rd_en", 32'(rd_en_a), 32'd0);
      check("idle_level_b", 32'(level_b), 32'd0);
    end

    // Streaming 0x01..0x10 with i_ready=1
    @(posedge clk); #1;
    for (int i = 1; i <= 16; i++) src_a.push_back(8'(i));
    first_rd = -1; first_v = -1; run = 0; max_run = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (rd_en_a && first_rd < 0) first_rd = c;
      if (valid_a) begin
        if (first_v < 0) first_v = c;
        run++;
        if (run > max_run) max_run = run;
      end else run = 0;
    end
    check("first_valid_latency", 32'(first_v - first_rd), 32'd2);
    check("stream_run_length", 32'(max_run), 32'd16);
    check("stream_drained", 32'(exp_a.size() + src_a.size()), 32'd0);

    // Backpressure: exactly BufDepth reads, head word held
    @(posedge clk); #1 ready_a = 1'b0;
    for (int i = 0; i < 6; i++) src_a.push_back(8'(8'h20 + i));
    reads = 0; stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rd_en_a) reads++;
      if (valid_a && data_a !== 8'h20) stable = 1'b0;
    end
    check("bp_reads", 32'(reads), 32'd3);
    check("bp_level", 32'(level_a), 32'd3);
    check("bp_valid", 32'(valid_a), 32'd1);
    check("bp_data", 32'(data_a), 32'h20);
    check("bp_stable", 32'(stable), 32'd1);
    base_a = delivered_a;
    @(posedge clk); #1 ready_a = 1'b1;
    for (int c = 0; c < 50 && (delivered_a - base_a) < 6; c++) @(posedge clk);
    check("bp_delivered", 32'(delivered_a - base_a), 32'd6);

    // Flush with two buffered and one in flight
    @(posedge clk); #1 ready_a = 1'b0;
    for (int i = 0; i < 6; i++) src_a.push_back(8'(8'h30 + i));
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (level_a == 2'd2) begin got = 1'b1; break; end
    end
    check("flush_setup", 32'(got), 32'd1);
    flush_a = 1'b1;
    @(negedge clk);
    check("flush_cycle_rd_en", 32'(rd_en_a), 32'd0);
    @(posedge clk); #1 flush_a = 1'b0; ready_a = 1'b1;
    check("flush_valid_next", 32'(valid_a), 32'd0);
    check("flush_level_next", 32'(level_a), 32'd0);
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (valid_a) begin got = 1'b1; break; end
    end
    check("post_flush_valid", 32'(got), 32'd1);
    check("post_flush_word", 32'(data_a), 32'h33);
    for (int c = 0; c < 50 && (exp_a.size() + src_a.size()) != 0; c++) @(posedge clk);
    check("post_flush_drained", 32'(exp_a.size() + src_a.size()), 32'd0);

    // Reset mid-stream after 5 of 10 words
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) src_a.push_back(8'(8'h40 + i));
    base_a = delivered_a;
    for (int c = 0; c < 40 && (delivered_a - base_a) < 5; c++) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("midrst_valid", 32'(valid_a), 32'd0);
    check("midrst_level", 32'(level_a), 32'd0);
    for (int c = 0; c < 60 && (exp_a.size() + src_a.size()) != 0; c++) @(posedge clk);
    check("midrst_drained", 32'(exp_a.size() + src_a.size()), 32'd0);

    // Random i_ready and random FIFO fill on both latencies
    base_a = delivered_a; base_b = delivered_b;
    for (int c = 0; c < 20000; c++) begin
      @(posedge clk); #1;
      if ((delivered_a - base_a) >= 1000 && (delivered_b - base_b) >= 1000) break;
      ready_a = 1'($urandom_range(0, 1));
      ready_b = 1'($urandom_range(0, 1));
      if (src_a.size() < 6 && $urandom_range(0, 2) != 0) src_a.push_back(8'($urandom_range(0, 255)));
      if (src_b.size() < 6 && $urandom_range(0, 2) != 0) src_b.push_back(8'($urandom_range(0, 255)));
    end
    ready_a = 1'b1; ready_b = 1'b1;
    for (int c = 0; c < 100 && (exp_a.size() + src_a.size() + exp_b.size() + src_b.size()) != 0; c++)
      @(posedge clk);
    check("random_count_a", 32'((delivered_a - base_a) >= 1000), 32'd1);
    check("random_count_b", 32'((delivered_b - base_b) >= 1000), 32'd1);
    check("random_drained_a", 32'(exp_a.size() + src_a.size()), 32'd0);
    check("random_drained_b", 32'(exp_b.size() + src_b.size()), 32'd0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
